mem_lock_arbiter: RTL and testbench
===================================

// Module: mem_lock_arbiter
//
// PURPOSE
// - Shares the single data-memory port among NUM_REQ requesters, e.g. the
//   core LSU/AMO path and a DMA engine.
// - Arbitration is round-robin.
// - A requester holds an atomic lock across a multi-cycle read-modify-write
//   sequence (load, wait, modify, store), so no other master can touch memory
//   between the AMO load and store.
// - Sits between the requesters and the memory interface; drives the muxed
//   memory request.
//
// PARAMETERS
// - NUM_REQ          2   number of requesters, 2..8
// - LOCK_MAX_CYCLES  16  lock watchdog limit in cycles, >=4; used only with
//                        LOCK_TIMEOUT_EN
//
// PORTS
// - clk           in   1          clock
// - reset_n       in   1          asynchronous, active-low reset
// - stall_i       in   1          memory not ready; freezes all arbiter state
// - req_i         in   NUM_REQ    per-requester access request
// - lock_i        in   NUM_REQ    per-requester "keep port after this access"
// - addr_i        in   NUM_REQ*32 per-requester address, packed, index 0 = LSBs
// - wdata_i       in   NUM_REQ*32 per-requester write data, packed
// - we_i          in   NUM_REQ*4  per-requester byte write enables, packed
// - gnt_o         out  NUM_REQ    one-hot grant; at most one bit set
// - mem_en_o      out  1          memory access enable
// - mem_we_o      out  4          memory byte write enables
// - mem_addr_o    out  32         memory address
// - mem_wdata_o   out  32         memory write data
// - locked_o      out  1          port currently locked by an owner
// - lock_abort_o  out  1          one-cycle pulse on forced lock release
//
// BEHAVIOUR
// - Reset: state IDLE, rr_ptr=NUM_REQ-1 (index 0 has first priority),
//   owner=0, timeout counter=0.
// - Reset outputs: gnt_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0,
//   mem_wdata_o=0, locked_o=0, lock_abort_o=0.
// - Grant is combinational from registered state plus req_i: zero-latency,
//   granted in the same cycle as the request.
// - IDLE: gnt_o = first set req_i bit searching from (rr_ptr+1) mod NUM_REQ
//   upward with wrap-around.
// - LOCKED: gnt_o = req_i[owner] at bit owner.
//   - req_i and lock_i from non-owners are ignored.
//   - Owner with req_i=0 (AMO wait/modify cycles): gnt_o=0, mem_en_o=0, and
//     the port stays reserved.
// - Completion: an access completes in a cycle with a grant bit set and
//   stall_i=0. On completion:
//   - rr_ptr <= granted index.
//   - IDLE with lock_i[g]=1: go to LOCKED, owner <= g.
//   - LOCKED with lock_i[owner]=0: go to IDLE. That is the final (store)
//     access, and it is still performed.
//   - LOCKED with lock_i[owner]=1: remain LOCKED.
// - stall_i=1: state, rr_ptr, owner and counter frozen.
//   - Requesters must hold req_i, lock_i, addr_i, wdata_i and we_i stable
//     while stalled, so gnt_o holds too.
// - Mux outputs:
//   - mem_en_o = |gnt_o.
//   - mem_addr_o, mem_wdata_o and mem_we_o come from the granted index;
//     all zero when there is no grant.
// - locked_o = (state==LOCKED).
// - No requests in IDLE: gnt_o=0, and rr_ptr is unchanged.
// - Reset mid-lock: immediate asynchronous return to IDLE; any in-flight
//   access is dropped.
//
// CONFIGURATION
// - Macro LOCK_TIMEOUT_EN defined:
//   - Counter cnt clears on entry to LOCKED and increments on each non-stalled
//     LOCKED cycle.
//   - When cnt==LOCK_MAX_CYCLES-1 and no completing unlock access occurs,
//     next state is IDLE and lock_abort_o pulses high for exactly that one
//     cycle.
//   - The ex-owner's later requests are arbitrated normally; rr_ptr <= owner.
//   - If an unlock completion and the timeout coincide, the normal unlock
//     wins and there is no abort pulse.
// - Macro LOCK_TIMEOUT_EN undefined:
//   - No counter; the lock persists until the owner releases it.
//   - lock_abort_o is tied to 0.
//
// TESTING
// - Reset, then req_i=2'b11 constant with lock_i=0 -> gnt_o alternates
//   01,10,01,10; mem_addr_o follows the granted requester.
// - Lock sequence: req0 lock=1 completes, then requester 1 requests while
//   req0 idles 2 cycles, then req0 stores with lock=0:
//   - requester 1 sees gnt_o[1]=0 throughout;
//   - locked_o=1 for 3 cycles;
//   - gnt_o[1] asserts in the cycle after the store.
// - stall_i=1 for 3 cycles during a grant to requester 1 -> gnt_o stays
//   2'b10, rr_ptr is unchanged, and the access completes on the first
//   cycle with stall_i=0.
// - Assert reset_n=0 while LOCKED with owner 1 -> gnt_o=0 and locked_o=0
//   immediately; after release, req_i=2'b11 is granted to 0 first.
// - LOCK_TIMEOUT_EN, LOCK_MAX_CYCLES=4: owner locks, then idles forever ->
//   lock_abort_o high for one cycle, 4 cycles after lock entry; waiting
//   requester granted the next cycle.
// - No-define build: same stimulus as the timeout test -> lock never
//   releases and lock_abort_o stays 0.

Source files
------------

// File: rtl/mem_lock_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_lock_arbiter                                              |
// | Purpose  : Round-robin arbiter for the single data-memory port, with an  |
// |            atomic lock so a requester keeps the port across a multi-     |
// |            cycle read-modify-write (load, wait, modify, store).          |
// | Config   : LOCK_TIMEOUT_EN (macro) enables a watchdog that force-releases|
// |            a lock held for LOCK_MAX_CYCLES cycles and pulses lock_abort_o|
// | Ports    : clk, reset_n (async, active-low), stall_i (memory not ready); |
// |            per-requester req_i/lock_i/addr_i/wdata_i/we_i (packed,       |
// |            index 0 in the LSBs); gnt_o one-hot grant; mem_* muxed memory |
// |            request; locked_o lock status; lock_abort_o forced release.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_lock_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int LOCK_MAX_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    lock_i,
    input  logic [NUM_REQ*32-1:0] addr_i,
    input  logic [NUM_REQ*32-1:0] wdata_i,
    input  logic [NUM_REQ*4-1:0]  we_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  locked_o,
    output logic                  lock_abort_o
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_MAX_CYCLES < 4) begin : g_param_check
        $error("mem_lock_arbiter: parameter out of range");
    end

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_idx_w-1:0]   rr_ptr_q, rr_ptr_d;
    logic [c_idx_w-1:0]   owner_q, owner_d;

    logic [NUM_REQ-1:0]   w_gnt_raw;
    logic [c_idx_w-1:0]   w_gnt_idx;
    logic                 w_done;

    // ------------------------------------------------------------------
    // Grant: zero-latency, from registered state and the live requests.
    // ------------------------------------------------------------------
    always_comb begin
        logic               found;
        logic [c_idx_w-1:0] idx;
        w_gnt_raw = '0;
        w_gnt_idx = '0;
        found     = 1'b0;
        idx       = '0;
        if (state_q == ST_LOCKED) begin
            // Only the owner can be served; others are ignored entirely.
            w_gnt_idx          = owner_q;
            w_gnt_raw[owner_q] = req_i[owner_q];
        end else begin
            // Search upward from the entry after the last served index.
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = c_idx_w'((int'(rr_ptr_q) + i) % NUM_REQ);
                if (!found && req_i[idx]) begin
                    found          = 1'b1;
                    w_gnt_raw[idx] = 1'b1;
                    w_gnt_idx      = idx;
                end
            end
        end
    end

    // Masking with reset_n keeps the grant low while reset is held even if
    // requesters keep driving req_i.
    assign gnt_o    = reset_n ? w_gnt_raw : '0;
    assign mem_en_o = |gnt_o;
    assign w_done   = mem_en_o & ~stall_i;
    assign locked_o = (state_q == ST_LOCKED);

    // ------------------------------------------------------------------
    // Memory request mux: AND-OR over the one-hot grant, zero when idle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) begin
                mem_addr_o  = mem_addr_o  | addr_i[k*32 +: 32];
                mem_wdata_o = mem_wdata_o | wdata_i[k*32 +: 32];
                mem_we_o    = mem_we_o    | we_i[k*4 +: 4];
            end
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int                 c_cnt_w   = $clog2(LOCK_MAX_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LOCK_MAX_CYCLES - 1);
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               w_abort;
`endif

    // ------------------------------------------------------------------
    // Next-state logic. Everything holds while the memory stalls.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
`ifdef LOCK_TIMEOUT_EN
        cnt_d    = cnt_q;
        w_abort  = 1'b0;
`endif
        if (!stall_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_done) begin
                        rr_ptr_d = w_gnt_idx;
                        if (lock_i[w_gnt_idx]) begin
                            state_d = ST_LOCKED;
                            owner_d = w_gnt_idx;
`ifdef LOCK_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end
                end
                ST_LOCKED: begin
`ifdef LOCK_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                    if (w_done) begin
                        rr_ptr_d = w_gnt_idx;
                    end
                    // The unlocking store is still performed this cycle.
                    if (w_done && !lock_i[owner_q]) begin
                        state_d = ST_IDLE;
                    end
`ifdef LOCK_TIMEOUT_EN
                    // A normal unlock takes precedence over the watchdog.
                    else if (cnt_q == c_cnt_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = owner_q;
                        w_abort  = 1'b1;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= c_idx_w'(NUM_REQ - 1);
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

`ifdef LOCK_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lock_abort_o = w_abort;
`else
    assign lock_abort_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_lock_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_lock_arbiter                                           |
// | Purpose  : Directed self-checking bench for mem_lock_arbiter (2 ports,   |
// |            LOCK_MAX_CYCLES=4). Expected outputs are queued when a cycle  |
// |            is driven and popped when the outputs are sampled.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_lock_arbiter;

    localparam int N    = 2;
    localparam int LMAX = 4;

    logic              clk;
    logic              reset_n;
    logic              stall_i;
    logic [N-1:0]      req_i;
    logic [N-1:0]      lock_i;
    logic [N*32-1:0]   addr_i;
    logic [N*32-1:0]   wdata_i;
    logic [N*4-1:0]    we_i;
    logic [N-1:0]      gnt_o;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              locked_o;
    logic              lock_abort_o;

    mem_lock_arbiter #(
        .NUM_REQ         (N),
        .LOCK_MAX_CYCLES (LMAX)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_i      (stall_i),
        .req_i        (req_i),
        .lock_i       (lock_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .we_i         (we_i),
        .gnt_o        (gnt_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .locked_o     (locked_o),
        .lock_abort_o (lock_abort_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [N-1:0] gnt;
        logic         en;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [3:0]   we;
        logic         lk;
        logic         ab;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   step        = 0;

    task automatic cmp(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s/%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            cmp(e.tag, "gnt",    32'(gnt_o),        32'(e.gnt));
            cmp(e.tag, "en",     32'(mem_en_o),     32'(e.en));
            cmp(e.tag, "addr",   mem_addr_o,        e.addr);
            cmp(e.tag, "wdata",  mem_wdata_o,       e.wdata);
            cmp(e.tag, "we",     32'(mem_we_o),     32'(e.we));
            cmp(e.tag, "locked", 32'(locked_o),     32'(e.lk));
            cmp(e.tag, "abort",  32'(lock_abort_o), 32'(e.ab));
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, queue the
    // expected outputs, then sample on the falling edge.
    task automatic cyc(input string tag, input logic rn, input logic st,
                       input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [N-1:0] eg, input logic el, input logic ea);
        exp_t        e;
        logic [31:0] a;
        @(posedge clk);
        #1;
        step++;
        e.tag   = tag;
        e.gnt   = eg;
        e.en    = |eg;
        e.addr  = '0;
        e.wdata = '0;
        e.we    = '0;
        e.lk    = el;
        e.ab    = ea;
        for (int k = 0; k < N; k++) begin
            a = {4'hA, 4'(k), 24'(step)};
            addr_i[k*32 +: 32]  = a;
            wdata_i[k*32 +: 32] = ~a;
            we_i[k*4 +: 4]      = 4'(k * 5 + 3);
            if (eg[k]) begin
                e.addr  = a;
                e.wdata = ~a;
                e.we    = 4'(k * 5 + 3);
            end
        end
        reset_n = rn;
        stall_i = st;
        req_i   = rq;
        lock_i  = lk;
        sb.push_back(e);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        reset_n = 1'b0;
        stall_i = 1'b0;
        req_i   = '0;
        lock_i  = '0;
        addr_i  = '0;
        wdata_i = '0;
        we_i    = '0;

        // Reset state, including requests held during reset.
        cyc("rst_idle", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc("rst_req",  1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);

        // Round-robin alternation, index 0 first.
        cyc("rr0", 1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0);
        cyc("rr1", 1'b1, 1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);
        cyc("rr2", 1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0);
        cyc("rr3", 1'b1, 1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);

        // Idle cycle leaves the pointer on 1, so 0 wins next.
        cyc("noreq",    1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        cyc("noreq_rr", 1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0);

        // Atomic sequence by requester 0 while requester 1 waits.
        cyc("lk_load",  1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        cyc("lk_wait1", 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        cyc("lk_wait2", 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        cyc("lk_store", 1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0);
        cyc("lk_after", 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0);

        // Stall during a grant to requester 1; pointer must not move.
        cyc("st_pre", 1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0);
        cyc("st_1",   1'b1, 1'b1, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);
        cyc("st_2",   1'b1, 1'b1, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);
        cyc("st_3",   1'b1, 1'b1, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);
        cyc("st_go",  1'b1, 1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);
        cyc("st_nxt", 1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0);

        // Reset while requester 1 owns the lock.
        cyc("rl_load", 1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
        cyc("rl_hold", 1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b0);
        cyc("rl_rst",  1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
        cyc("rl_rel0", 1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0);
        cyc("rl_rel1", 1'b1, 1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);

        // Owner 0 locks and then goes silent while requester 1 waits.
        cyc("to_load", 1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
`ifdef LOCK_TIMEOUT_EN
        cyc("to_w0",   1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        cyc("to_w1",   1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        cyc("to_w2",   1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        cyc("to_abrt", 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1);
        cyc("to_next", 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0);
`else
        for (int i = 0; i < 8; i++) begin
            cyc("nt_wait", 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
